// File: rtl/fg_pkg.sv
// Shared types and helpers for the function-generator output stage.
// Holds the ramp FSM state encoding and the sample saturation helper.
package fg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } fg_ramp_state_t;

  localparam int unsigned FG_BITWIDTH   = 16;
  localparam int signed   FG_SAMPLE_MAX = (2 ** (FG_BITWIDTH - 1)) - 1;
  localparam int signed   FG_SAMPLE_MIN = -(2 ** (FG_BITWIDTH - 1));

  // Working width for fg_sat; callers sign-extend into it (bw + 2 must fit).
  localparam int unsigned FG_SAT_W = 40;

  function automatic logic signed [FG_SAT_W-1:0] fg_sat(
    input logic signed [FG_SAT_W-1:0] v,
    input int unsigned                bw
  );
    logic signed [FG_SAT_W-1:0] hi;
    logic signed [FG_SAT_W-1:0] lo;
    hi = {{(FG_SAT_W - 1){1'b0}}, 1'b1} <<< (bw - 1);
    hi = hi - FG_SAT_W'(1);
    lo = ~hi;
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fg_ramp_ctrl.sv
// Soft enable/disable gain ramp: FSM plus gain counter, advancing only on strobe_i.
// Gain runs 0..2^RAMP_BITS, one step per strobe.
module fg_ramp_ctrl
  import fg_pkg::*;
#(
  parameter int unsigned RAMP_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 strobe_i,
  input  logic                 enable_i,
  output logic [RAMP_BITS:0]   gain_o,
  output logic                 active_o
);

  localparam logic [RAMP_BITS:0] GAIN_MAX = {1'b1, {RAMP_BITS{1'b0}}};
  localparam logic [RAMP_BITS:0] GAIN_ONE = (RAMP_BITS + 1)'(1);

  fg_ramp_state_t       state_q, state_d;
  logic [RAMP_BITS:0]   gain_q, gain_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  // Reversals can enter RAMP_UP at full gain or RAMP_DOWN at zero gain,
  // so both ramps finish on the current gain before stepping past a limit.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (strobe_i) begin
      unique case (state_q)
        IDLE: begin
          gain_d = '0;
          if (enable_i) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (!enable_i) begin
            state_d = RAMP_DOWN;
          end else if (gain_q == GAIN_MAX) begin
            state_d = RUN;
          end else begin
            gain_d = gain_q + GAIN_ONE;
            if (gain_d == GAIN_MAX) state_d = RUN;
          end
        end
        RUN: begin
          gain_d = GAIN_MAX;
          if (!enable_i) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (enable_i) begin
            state_d = RAMP_UP;
          end else if (gain_q == '0) begin
            state_d = IDLE;
          end else begin
            gain_d = gain_q - GAIN_ONE;
            if (gain_d == '0) state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    gain_o   = gain_q;
    active_o = (state_q != IDLE);
  end

endmodule

// File: rtl/fg_output_stage.sv
// Registered output stage: channel select + offset, saturate/wrap, soft gain ramp.
// Build option FG_OUTPUT_SATURATE_EN enables clamping and the sticky clip flag.
module fg_output_stage
  import fg_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 16,
  parameter int unsigned DATA_COUNT = 3,
  parameter int unsigned RAMP_BITS  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  strobe_i,
  input  logic                                  enable_i,
  input  logic [$clog2(DATA_COUNT)-1:0]         select_i,
  input  logic signed [BITWIDTH-1:0]            offset_i,
  input  logic [DATA_COUNT*(BITWIDTH+1)-1:0]    data_i,
  input  logic                                  clear_i,
  output logic signed [BITWIDTH-1:0]            out_o,
  output logic                                  valid_o,
  output logic                                  clip_o,
  output logic                                  active_o
);

  localparam int unsigned SUM_W  = BITWIDTH + 2;
  localparam int unsigned GAIN_W = RAMP_BITS + 1;
  localparam int unsigned PROD_W = BITWIDTH + GAIN_W + 1;

  logic [GAIN_W-1:0]          gain_cur;
  logic signed [BITWIDTH:0]   sample;
  logic signed [SUM_W-1:0]    sum_d;

  logic signed [SUM_W-1:0]    sum_q;
  logic [GAIN_W-1:0]          gain_q;
  logic                       v1_q;

  logic signed [BITWIDTH-1:0] sat;
  logic signed [PROD_W-1:0]   prod;
  logic signed [BITWIDTH-1:0] out_d;
  logic                       clip_hit;

  fg_ramp_ctrl #(
    .RAMP_BITS (RAMP_BITS)
  ) u_ramp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .strobe_i (strobe_i),
    .enable_i (enable_i),
    .gain_o   (gain_cur),
    .active_o (active_o)
  );

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    sample = data_i[0 +: BITWIDTH + 1];
    for (int unsigned k = 1; k < DATA_COUNT; k++) begin
      if (32'(select_i) == k) sample = data_i[k*(BITWIDTH+1) +: BITWIDTH + 1];
    end
    sum_d = SUM_W'(sample) + SUM_W'(offset_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      gain_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= strobe_i;
      if (strobe_i) begin
        sum_q  <= sum_d;
        gain_q <= gain_cur;
      end
    end
  end

`ifdef FG_OUTPUT_SATURATE_EN
  logic signed [FG_SAT_W-1:0] sat_full;

  always_comb begin
    sat_full = fg_sat(FG_SAT_W'(sum_q), BITWIDTH);
    sat      = sat_full[BITWIDTH-1:0];
    clip_hit = (sat_full != FG_SAT_W'(sum_q));
  end

  logic clip_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clip_q <= 1'b0;
    end else if (v1_q && clip_hit) begin
      clip_q <= 1'b1;
    end else if (clear_i) begin
      clip_q <= 1'b0;
    end
  end

  assign clip_o = clip_q;
`else
  logic [SUM_W-BITWIDTH-1:0] sum_hi_unused;
  logic                      clear_unused;

  always_comb begin
    sat      = sum_q[BITWIDTH-1:0];
    clip_hit = 1'b0;
  end

  assign sum_hi_unused = sum_q[SUM_W-1:BITWIDTH];
  assign clear_unused  = clear_i | clip_hit;
  assign clip_o        = 1'b0;
`endif

  // Gain is zero-extended so the product stays signed; >>> floors toward -inf.
  always_comb begin
    prod  = PROD_W'(sat) * PROD_W'($signed({1'b0, gain_q}));
    out_d = BITWIDTH'(prod >>> RAMP_BITS);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= v1_q;
      if (v1_q) out_o <= out_d;
    end
  end

endmodule

// File: tb/tb_fg_output_stage.sv
// Directed self-checking bench for fg_output_stage (BITWIDTH=16, DATA_COUNT=3, RAMP_BITS=2).
// Expectations follow FG_OUTPUT_SATURATE_EN when defined, legacy wrap otherwise.
module tb_fg_output_stage;

`ifdef FG_OUTPUT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               strobe;
  logic               enable;
  logic [1:0]         sel;
  logic signed [15:0] offset;
  logic [50:0]        data;
  logic               clear;
  logic signed [15:0] out;
  logic               valid;
  logic               clip;
  logic               active;

  int tests = 0;
  int fails = 0;

  fg_output_stage #(
    .BITWIDTH   (16),
    .DATA_COUNT (3),
    .RAMP_BITS  (2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .strobe_i (strobe),
    .enable_i (enable),
    .select_i (sel),
    .offset_i (offset),
    .data_i   (data),
    .clear_i  (clear),
    .out_o    (out),
    .valid_o  (valid),
    .clip_o   (clip),
    .active_o (active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int v);
    data[k*17 +: 17] = 17'(v);
  endtask

  task automatic test_reset();
    rst = 1'b1; strobe = 1'b0; enable = 1'b0; sel = 2'd0;
    offset = '0; data = '0; clear = 1'b0;
    #2;
    repeat (2) tick();
    tests++; if (out !== 16'sd0) begin fails++; $display("FAIL reset_out got=%0d exp=0", out); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    tests++; if (clip !== 1'b0) begin fails++; $display("FAIL reset_clip got=%b exp=0", clip); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active got=%b exp=0", active); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp_up();
    int exp_out[6] = '{0, 0, 256, 512, 768, 1024};
    set_ch(1, 1000); offset = 16'sd24; sel = 2'd1; enable = 1'b1; strobe = 1'b1;
    tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL up_latency valid got=%b exp=0", valid); end
    tests++; if (active !== 1'b1) begin fails++; $display("FAIL up_active got=%b exp=1", active); end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL up_valid[%0d] got=%b exp=1", i, valid); end
      tests++; if (out !== 16'(exp_out[i])) begin fails++; $display("FAIL up_out[%0d] got=%0d exp=%0d", i, out, exp_out[i]); end
    end
  endtask

  task automatic test_ramp_down();
    int exp_out[8] = '{1024, 1024, 1024, 768, 512, 256, 0, 0};
    bit exp_act[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++; if (out !== 16'(exp_out[i])) begin fails++; $display("FAIL down_out[%0d] got=%0d exp=%0d", i, out, exp_out[i]); end
      tests++; if (active !== exp_act[i]) begin fails++; $display("FAIL down_active[%0d] got=%b exp=%b", i, active, exp_act[i]); end
    end
  endtask

  task automatic test_saturation();
    int e;
    set_ch(1, 32767); offset = 16'sd100; enable = 1'b1;
    repeat (8) tick();
    e = SAT ? 32767 : -32669;
    tests++; if (out !== 16'(e)) begin fails++; $display("FAIL sat_pos_out got=%0d exp=%0d", out, e); end
    tests++; if (clip !== SAT) begin fails++; $display("FAIL sat_pos_clip got=%b exp=%b", clip, SAT); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++; if (clip !== SAT) begin fails++; $display("FAIL sat_set_wins got=%b exp=%b", clip, SAT); end
    set_ch(1, 1000); offset = 16'sd24;
    repeat (3) tick();
    tests++; if (out !== 16'sd1024) begin fails++; $display("FAIL sat_inrange_out got=%0d exp=1024", out); end
    tests++; if (clip !== SAT) begin fails++; $display("FAIL sat_sticky got=%b exp=%b", clip, SAT); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++; if (clip !== 1'b0) begin fails++; $display("FAIL sat_clear got=%b exp=0", clip); end
    set_ch(1, -32768); offset = -16'sd1;
    repeat (3) tick();
    e = SAT ? -32768 : 32767;
    tests++; if (out !== 16'(e)) begin fails++; $display("FAIL sat_neg_out got=%0d exp=%0d", out, e); end
    tests++; if (clip !== SAT) begin fails++; $display("FAIL sat_neg_clip got=%b exp=%b", clip, SAT); end
  endtask

  task automatic test_async_reset();
    set_ch(1, 1000); offset = 16'sd24; enable = 1'b0;
    repeat (2) tick();
    tests++; if (out !== 16'sd1024) begin fails++; $display("FAIL arst_pre_out got=%0d exp=1024", out); end
    tests++; if (active !== 1'b1) begin fails++; $display("FAIL arst_pre_active got=%b exp=1", active); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (out !== 16'sd0) begin fails++; $display("FAIL arst_out got=%0d exp=0", out); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL arst_valid got=%b exp=0", valid); end
    tests++; if (clip !== 1'b0) begin fails++; $display("FAIL arst_clip got=%b exp=0", clip); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL arst_active got=%b exp=0", active); end
    tick();
    rst = 1'b0; enable = 1'b1;
    tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL arst_restart_valid got=%b exp=0", valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (out !== 16'sd0) begin fails++; $display("FAIL arst_restart_out[%0d] got=%0d exp=0", i, out); end
    end
  endtask

  task automatic test_reenable();
    int exp_out[5] = '{512, 512, 512, 768, 1024};
    enable = 1'b0;
    tick();
    tests++; if (out !== 16'sd256) begin fails++; $display("FAIL reen_drop_out got=%0d exp=256", out); end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (out !== 16'(exp_out[i])) begin fails++; $display("FAIL reen_out[%0d] got=%0d exp=%0d", i, out, exp_out[i]); end
    end
    tests++; if (active !== 1'b1) begin fails++; $display("FAIL reen_active got=%b exp=1", active); end
  endtask

  task automatic test_select_gap();
    int exp_out[5] = '{-401, -401, -301, -201, -101};
    sel = 2'd3; set_ch(0, -400); offset = 16'sd0;
    repeat (3) tick();
    tests++; if (out !== -16'sd400) begin fails++; $display("FAIL sel_fallback_out got=%0d exp=-400", out); end
    strobe = 1'b0;
    repeat (3) tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL gap_idle_valid got=%b exp=0", valid); end
    enable = 1'b0; set_ch(0, -401);
    repeat (4) tick();
    tests++; if (out !== -16'sd400) begin fails++; $display("FAIL gap_hold_out got=%0d exp=-400", out); end
    tests++; if (active !== 1'b1) begin fails++; $display("FAIL gap_hold_active got=%b exp=1", active); end
    for (int i = 0; i < 5; i++) begin
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick();
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL gap_valid[%0d] got=%b exp=1", i, valid); end
      tests++; if (out !== 16'(exp_out[i])) begin fails++; $display("FAIL gap_out[%0d] got=%0d exp=%0d", i, out, exp_out[i]); end
      repeat (3) tick();
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL gap_novalid[%0d] got=%b exp=0", i, valid); end
      tests++; if (out !== 16'(exp_out[i])) begin fails++; $display("FAIL gap_holdout[%0d] got=%0d exp=%0d", i, out, exp_out[i]); end
    end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL gap_end_active got=%b exp=0", active); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_saturation();
    test_async_reset();
    test_reenable();
    test_select_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
